// File: rtl/rotor_stepper_n.sv
// Rotor-position stepping engine for N Enigma rotors.
// Supports mechanical double-step and odometer stepping, static leftmost rotors,
// multi-notch rotors, a step counter and one-cycle period/wrap pulses.
// All next-state decisions come from registered positions in a single cycle.
module rotor_stepper_n #(
    parameter int NR    = 3,
    parameter int NSTEP = 3,
    parameter int ALPHA = 26,
    parameter int W     = 5,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [NR*W-1:0]       init_pos,
    input  logic [NR*ALPHA-1:0]   notch,
    input  logic                  step,
    input  logic                  mode,
    output logic [NR*W-1:0]       pos,
    output logic [CW-1:0]         step_cnt,
    output logic                  cycle_done,
    output logic                  wrap,
    output logic                  load_err
);

    // Registered state (stage 1).
    logic [W-1:0]     pos_p1   [NR];
    logic [W-1:0]     start_p1 [NR];
    logic [CW-1:0]    cnt_p1;
    logic             done_p1;
    logic             wrap_p1;
    logic             lerr_p1;

    // Combinational next-state terms derived from stage-1 registers (stage 0).
    logic [W-1:0]     init_p0  [NR];
    logic [NR-1:0]    bad_p0;
    logic [NR-1:0]    hit_p0;
    logic [NSTEP-1:0] en_mech_p0;
    logic [NSTEP-1:0] en_odo_p0;
    logic [NSTEP-1:0] sel_p0;
    logic [NSTEP:0]   run_max_p0;
    logic [W-1:0]     nxt_p0   [NR];
    logic             match_p0;
    logic             unused_hits;

    // Modular increment; the only arithmetic ever applied to a position.
    function automatic logic [W-1:0] inc_pos(input logic [W-1:0] p);
        return (p == W'(ALPHA - 1)) ? '0 : p + W'(1);
    endfunction

    // Notch lookup that never indexes beyond the alphabet.
    function automatic logic notch_at(input logic [ALPHA-1:0] mask,
                                      input logic [W-1:0]     p);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < ALPHA; k++) begin
            if (p == W'(k)) begin
                hit = mask[k];
            end
        end
        return hit;
    endfunction

    // Sanitise load values: out-of-alphabet slices load as 0 and flag an error.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bad_p0[i]  = int'(init_pos[i*W +: W]) >= ALPHA;
            init_p0[i] = bad_p0[i] ? '0 : init_pos[i*W +: W];
        end
    end

    // Per-rotor notch hit at its current position; only the lower rotors'
    // hits drive stepping, the rest are folded into a discard term.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            hit_p0[i] = notch_at(notch[i*ALPHA +: ALPHA], pos_p1[i]);
        end
        unused_hits = ^hit_p0;
    end

    // Mechanical enables: pawl from the right neighbour's notch, plus the
    // double-step of a middle rotor sitting on its own notch.
    always_comb begin
        en_mech_p0    = '0;
        en_mech_p0[0] = 1'b1;
        for (int i = 1; i < NSTEP; i++) begin
            en_mech_p0[i] = hit_p0[i-1];
            if (i < NSTEP - 1) begin
                en_mech_p0[i] = en_mech_p0[i] | hit_p0[i];
            end
        end
    end

    // Odometer enables: a rotor moves when every faster rotor is at its last
    // position; the carry past the last stepping rotor is the wrap.
    always_comb begin
        run_max_p0    = '0;
        run_max_p0[0] = 1'b1;
        for (int i = 0; i < NSTEP; i++) begin
            run_max_p0[i+1] = run_max_p0[i] & (pos_p1[i] == W'(ALPHA - 1));
        end
        en_odo_p0 = run_max_p0[NSTEP-1:0];
    end

    // Next positions for an accepted step and the return-to-start compare.
    always_comb begin
        sel_p0   = mode ? en_odo_p0 : en_mech_p0;
        match_p0 = 1'b1;
        for (int i = 0; i < NR; i++) begin
            nxt_p0[i] = pos_p1[i];
        end
        for (int i = 0; i < NSTEP; i++) begin
            if (sel_p0[i]) begin
                nxt_p0[i] = inc_pos(pos_p1[i]);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (nxt_p0[i] != start_p1[i]) begin
                match_p0 = 1'b0;
            end
        end
    end

    // State update with priority reset > load > step > hold; pulses self-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                pos_p1[i]   <= '0;
                start_p1[i] <= '0;
            end
            cnt_p1  <= '0;
            done_p1 <= 1'b0;
            wrap_p1 <= 1'b0;
            lerr_p1 <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < NR; i++) begin
                pos_p1[i]   <= init_p0[i];
                start_p1[i] <= init_p0[i];
            end
            cnt_p1  <= '0;
            done_p1 <= 1'b0;
            wrap_p1 <= 1'b0;
            lerr_p1 <= |bad_p0;
        end else if (step) begin
            for (int i = 0; i < NR; i++) begin
                pos_p1[i] <= nxt_p0[i];
            end
            cnt_p1  <= cnt_p1 + CW'(1);
            done_p1 <= match_p0;
            wrap_p1 <= mode & run_max_p0[NSTEP];
        end else begin
            done_p1 <= 1'b0;
            wrap_p1 <= 1'b0;
        end
    end

    // Flatten registered positions onto the output bus.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            pos[i*W +: W] = pos_p1[i];
        end
    end

    assign step_cnt   = cnt_p1;
    assign cycle_done = done_p1;
    assign wrap       = wrap_p1;
    assign load_err   = lerr_p1;

endmodule

// File: tb/tb_rotor_stepper_n.sv
// Directed bench for rotor_stepper_n (NR=4, NSTEP=3, ALPHA=26) with a
// position-level reference model checked on every cycle.
module tb_rotor_stepper_n;

    localparam int NR    = 4;
    localparam int NSTEP = 3;
    localparam int ALPHA = 26;
    localparam int W     = 5;
    localparam int CW    = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                load;
    logic [NR*W-1:0]     init_pos;
    logic [NR*ALPHA-1:0] notch;
    logic                step;
    logic                mode;
    logic [NR*W-1:0]     pos;
    logic [CW-1:0]       step_cnt;
    logic                cycle_done;
    logic                wrap;
    logic                load_err;

    always #5 clk = ~clk;

    rotor_stepper_n #(.NR(NR), .NSTEP(NSTEP), .ALPHA(ALPHA), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .load(load), .init_pos(init_pos),
        .notch(notch), .step(step), .mode(mode), .pos(pos),
        .step_cnt(step_cnt), .cycle_done(cycle_done), .wrap(wrap),
        .load_err(load_err)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: rotor positions as plain integers.
    int m_pos   [NR];
    int m_start [NR];
    int m_cnt;
    bit m_done, m_wrap, m_err;

    task automatic model_step();
        int old [NR];
        int val, w, total;
        old = m_pos;
        if (mode) begin
            // Stepping rotors read as one base-ALPHA number that counts up.
            val = 0;
            w   = 1;
            for (int i = 0; i < NSTEP; i++) begin
                val += old[i] * w;
                w   *= ALPHA;
            end
            total  = w;
            m_wrap = (val == total - 1);
            val    = (val + 1) % total;
            for (int i = 0; i < NSTEP; i++) begin
                m_pos[i] = val % ALPHA;
                val      = val / ALPHA;
            end
        end else begin
            m_wrap   = 1'b0;
            m_pos[0] = (old[0] + 1) % ALPHA;
            for (int i = 1; i < NSTEP; i++) begin
                if (notch[(i-1)*ALPHA + old[i-1]] ||
                    (i < NSTEP - 1 && notch[i*ALPHA + old[i]]))
                    m_pos[i] = (old[i] + 1) % ALPHA;
            end
        end
        m_cnt  = (m_cnt + 1) % (1 << CW);
        m_done = 1'b1;
        for (int i = 0; i < NR; i++)
            if (m_pos[i] != m_start[i]) m_done = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_pos[i]   = 0;
                m_start[i] = 0;
            end
            m_cnt = 0; m_done = 0; m_wrap = 0; m_err = 0;
        end else if (load) begin
            m_err = 0;
            for (int i = 0; i < NR; i++) begin
                int v;
                v = int'(init_pos[i*W +: W]);
                if (v >= ALPHA) begin
                    v     = 0;
                    m_err = 1;
                end
                m_pos[i]   = v;
                m_start[i] = v;
            end
            m_cnt = 0; m_done = 0; m_wrap = 0;
        end else if (step) begin
            model_step();
        end else begin
            m_done = 0; m_wrap = 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NR*W-1:0] e;
            for (int i = 0; i < NR; i++) e[i*W +: W] = W'(m_pos[i]);
            check("model_pos", pos, e);
            check("model_cnt", step_cnt, m_cnt);
            check("model_done", cycle_done, m_done);
            check("model_wrap", wrap, m_wrap);
            check("model_err", load_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rot(input int i);
        return int'(pos[i*W +: W]);
    endfunction

    task automatic do_load(input logic [NR*W-1:0] v);
        init_pos = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        int done_at;
        reset = 1'b1; load = 1'b0; step = 1'b0; mode = 1'b0;
        init_pos = '0; notch = '0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_pos", pos, 0);
        check("reset_cnt", step_cnt, 0);
        check("reset_flags", {cycle_done, wrap, load_err}, 0);
        reset = 1'b0;

        // Double-step sequence.
        notch = '0;
        notch[0*ALPHA + 21] = 1'b1;
        notch[1*ALPHA + 4]  = 1'b1;
        notch[2*ALPHA + 16] = 1'b1;
        do_load({5'd0, 5'd0, 5'd3, 5'd20});
        step = 1'b1;
        tick();
        check("ds_step1", {rot(2), rot(1), rot(0)}, {32'd0, 32'd3, 32'd21});
        tick();
        check("ds_step2", {rot(2), rot(1), rot(0)}, {32'd0, 32'd4, 32'd22});
        tick();
        check("ds_step3", {rot(2), rot(1), rot(0)}, {32'd1, 32'd5, 32'd23});
        step = 1'b0;
        check("ds_cnt", step_cnt, 3);

        // Mechanical period.
        do_load('0);
        step = 1'b1;
        done_at = -1;
        for (int k = 1; k <= 20000; k++) begin
            tick();
            if (cycle_done) begin
                done_at = k;
                break;
            end
        end
        step = 1'b0;
        check("mech_period", done_at, 16900);
        check("mech_period_cnt", step_cnt, 16900);
        tick();
        check("done_clears", cycle_done, 0);

        // Odometer carry and wrap.
        mode = 1'b1;
        do_load({5'd0, 5'd25, 5'd25, 5'd24});
        step = 1'b1;
        tick();
        check("odo_step1", {rot(2), rot(1), rot(0)}, {32'd25, 32'd25, 32'd25});
        check("odo_wrap1", wrap, 0);
        tick();
        check("odo_step2", {rot(2), rot(1), rot(0)}, {32'd0, 32'd0, 32'd0});
        check("odo_wrap2", wrap, 1);
        step = 1'b0;
        tick();
        check("wrap_clears", wrap, 0);

        // Odometer period.
        do_load('0);
        step = 1'b1;
        done_at = -1;
        for (int k = 1; k <= 20000; k++) begin
            tick();
            if (cycle_done) begin
                done_at = k;
                break;
            end
        end
        step = 1'b0;
        check("odo_period", done_at, 17576);
        check("odo_period_wrap", wrap, 1);

        // Multi-notch rotor 0 and static rotor 3.
        mode  = 1'b0;
        notch = '0;
        notch[0*ALPHA + 12] = 1'b1;
        notch[0*ALPHA + 25] = 1'b1;
        do_load({5'd7, 5'd0, 5'd0, 5'd11});
        step = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("mn_rotor1", rot(1), (k >= 15) ? 2 : ((k >= 2) ? 1 : 0));
            check("mn_rotor3", rot(3), 7);
        end
        step = 1'b0;

        // Load and step together: load wins.
        step = 1'b1;
        tick();
        init_pos = {5'd0, 5'd0, 5'd0, 5'd5};
        load     = 1'b1;
        tick();
        load = 1'b0;
        step = 1'b0;
        check("ls_cnt", step_cnt, 0);
        check("ls_pos", pos, {5'd0, 5'd0, 5'd0, 5'd5});

        // Out-of-alphabet load, sticky error, cleared by a valid load.
        do_load({5'd0, 5'd0, 5'd30, 5'd4});
        check("bad_slice", {rot(1), rot(0)}, {32'd0, 32'd4});
        check("bad_err", load_err, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("bad_err_sticky", load_err, 1);
        do_load({5'd0, 5'd1, 5'd2, 5'd3});
        check("err_cleared", load_err, 0);

        // Reset during a step burst, with load also requested.
        do_load({5'd2, 5'd30, 5'd25, 5'd25});
        mode = 1'b1;
        step = 1'b1;
        tick();
        tick();
        tick();
        reset    = 1'b1;
        load     = 1'b1;
        init_pos = {5'd1, 5'd1, 5'd1, 5'd1};
        tick();
        check("rst_pos", pos, 0);
        check("rst_cnt", step_cnt, 0);
        check("rst_flags", {cycle_done, wrap, load_err}, 0);
        reset = 1'b0;
        load  = 1'b0;
        step  = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
